// File: rtl/wb_pkg.sv
// wb_pkg: shared types and width defaults for the write-back unit
package wb_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_LANES = 4;
  typedef enum logic [1:0] {MTR_ALU, MTR_MEM, MTR_SBOX, MTR_RCON} memtoreg_e;
  typedef enum logic [1:0] {IDLE, FILL, PEND} pack_state_e;
endpackage

// File: rtl/vreg_packer.sv
// vreg_packer: packs per-cycle lanes into vector register writes with a held output buffer
module vreg_packer import wb_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES = DEF_LANES,
  parameter int REG_AW = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_i,
  input  logic [REG_AW-1:0]        rd_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     ready_i,
  output logic                     we_o,
  output logic [REG_AW-1:0]        waddr_o,
  output logic [DATA_W*LANES-1:0]  wdata_o,
  output logic [LANES-1:0]         wmask_o,
  output logic                     stall_o
);
  localparam int CW = $clog2(LANES);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [REG_AW-1:0] tgt_q, tgt_d, addr_q, addr_d;
  logic [DATA_W-1:0] acc_q [LANES];
  logic [DATA_W-1:0] acc_d [LANES];
  logic we_q, we_d;
  logic [DATA_W*LANES-1:0] data_q, data_d, edata;
  logic [LANES-1:0] mask_q, mask_d, emask;
  pack_state_e state;
  logic pack, flush, emit, accept, restart;
  always_comb begin
    state = we_q ? PEND : (cnt_q != '0 ? FILL : IDLE);
    restart = cnt_q == '0 || rd_i != tgt_q;
    pack = cnt_q != '0 && rd_i == tgt_q && cnt_q == CW'(LANES - 1);
    flush = cnt_q != '0 && rd_i != tgt_q;
    emit = valid_i && (pack || flush);
    stall_o = state == PEND && !ready_i && emit;
    accept = valid_i && !stall_o;
    // lanes past the fill point may hold stale data from earlier vectors, so mask them to zero
    for (int i = 0; i < LANES; i++) begin
      emask[i] = pack || i < int'(cnt_q);
      edata[i*DATA_W +: DATA_W] = !emask[i] ? '0 : (pack && i == LANES - 1 ? data_i : acc_q[i]);
    end
    cnt_d = cnt_q;
    tgt_d = tgt_q;
    acc_d = acc_q;
    we_d = we_q && !ready_i;
    addr_d = addr_q;
    data_d = data_q;
    mask_d = mask_q;
    if (accept) begin
      acc_d[restart ? CW'(0) : cnt_q] = data_i;
      tgt_d = rd_i;
      cnt_d = restart ? CW'(1) : (pack ? '0 : cnt_q + 1'b1);
      if (emit) begin
        we_d = 1'b1;
        addr_d = tgt_q;
        data_d = edata;
        mask_d = emask;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tgt_q <= '0;
      acc_q <= '{default: '0};
      we_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      mask_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      tgt_q <= tgt_d;
      acc_q <= acc_d;
      we_q <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      mask_q <= mask_d;
    end
  end
  assign we_o = we_q;
  assign waddr_o = addr_q;
  assign wdata_o = data_q;
  assign wmask_o = mask_q;
endmodule

// File: rtl/wb_writeback_unit.sv
// wb_writeback_unit: result select, scalar RF write and vector lane packing for the AES WB stage
// Define WB_FWD_EN to expose the combinational scalar bypass (fwd_valid/fwd_rd/fwd_data).
module wb_writeback_unit import wb_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES = DEF_LANES,
  parameter int REG_AW = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        WB_MemData,
  input  logic [DATA_W-1:0]        WB_ALUResult,
  input  logic [DATA_W-1:0]        WB_sbox,
  input  logic [DATA_W-1:0]        WB_rcon,
  input  logic [REG_AW-1:0]        WB_rd,
  input  logic [1:0]               WB_MemToReg,
  input  logic                     WB_RegWrite,
  input  logic                     WB_VRegWrite,
  input  logic                     vrf_ready,
  output logic                     rf_we,
  output logic [REG_AW-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic                     vrf_we,
  output logic [REG_AW-1:0]        vrf_waddr,
  output logic [DATA_W*LANES-1:0]  vrf_wdata,
  output logic [LANES-1:0]         vrf_wmask,
  output logic                     wb_stall
`ifdef WB_FWD_EN
  ,
  output logic                     fwd_valid,
  output logic [REG_AW-1:0]        fwd_rd,
  output logic [DATA_W-1:0]        fwd_data
`endif
);
  memtoreg_e sel;
  logic [DATA_W-1:0] result;
  logic scalar_we;
  logic rf_we_q;
  logic [REG_AW-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  always_comb begin
    sel = memtoreg_e'(WB_MemToReg);
    result = sel == MTR_ALU ? WB_ALUResult : sel == MTR_MEM ? WB_MemData :
             sel == MTR_SBOX ? WB_sbox : WB_rcon;
    scalar_we = WB_RegWrite && WB_rd != '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= scalar_we;
      rf_waddr_q <= WB_rd;
      rf_wdata_q <= result;
    end
  end
  assign rf_we = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
`ifdef WB_FWD_EN
  assign fwd_valid = scalar_we;
  assign fwd_rd = WB_rd;
  assign fwd_data = result;
`endif
  vreg_packer #(.DATA_W(DATA_W), .LANES(LANES), .REG_AW(REG_AW)) u_packer (
    .clk(clk),
    .rst_n(rst_n),
    .valid_i(WB_VRegWrite),
    .rd_i(WB_rd),
    .data_i(result),
    .ready_i(vrf_ready),
    .we_o(vrf_we),
    .waddr_o(vrf_waddr),
    .wdata_o(vrf_wdata),
    .wmask_o(vrf_wmask),
    .stall_o(wb_stall)
  );
endmodule

// File: tb/tb_wb_writeback_unit.sv
// tb_wb_writeback_unit: directed stimulus with queue scoreboard for wb_writeback_unit
module tb_wb_writeback_unit;
  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] WB_MemData, WB_ALUResult, WB_sbox, WB_rcon;
  logic [4:0] WB_rd;
  logic [1:0] WB_MemToReg;
  logic WB_RegWrite, WB_VRegWrite, vrf_ready;
  logic rf_we, vrf_we, wb_stall;
  logic [4:0] rf_waddr, vrf_waddr;
  logic [31:0] rf_wdata;
  logic [127:0] vrf_wdata;
  logic [3:0] vrf_wmask;

  always #5 clk = ~clk;

  wb_writeback_unit dut (
    .clk(clk), .rst_n(rst_n),
    .WB_MemData(WB_MemData), .WB_ALUResult(WB_ALUResult), .WB_sbox(WB_sbox), .WB_rcon(WB_rcon),
    .WB_rd(WB_rd), .WB_MemToReg(WB_MemToReg), .WB_RegWrite(WB_RegWrite), .WB_VRegWrite(WB_VRegWrite),
    .vrf_ready(vrf_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .vrf_we(vrf_we), .vrf_waddr(vrf_waddr), .vrf_wdata(vrf_wdata), .vrf_wmask(vrf_wmask),
    .wb_stall(wb_stall)
  );

  typedef struct {logic [4:0] a; logic [31:0] d;} sexp_t;
  typedef struct {logic [4:0] a; logic [127:0] d; logic [3:0] m;} vexp_t;
  sexp_t sq[$];
  vexp_t vq[$];
  sexp_t se;
  vexp_t ve;
  int total = 0, bad = 0;
  logic hold = 1'b0;
  logic [4:0] pa;
  logic [127:0] pd;
  logic [3:0] pm;

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic set_res(input logic [1:0] sel, input logic [31:0] d);
    WB_MemToReg = sel;
    WB_ALUResult = $urandom;
    WB_MemData = $urandom;
    WB_sbox = $urandom;
    WB_rcon = $urandom;
    if (sel == 2'd0) WB_ALUResult = d;
    else if (sel == 2'd1) WB_MemData = d;
    else if (sel == 2'd2) WB_sbox = d;
    else WB_rcon = d;
  endtask

  task automatic sc(input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] d);
    set_res(sel, d);
    WB_rd = rd;
    WB_RegWrite = 1'b1;
    WB_VRegWrite = 1'b0;
    if (rd != 5'd0) sq.push_back('{a: rd, d: d});
    @(posedge clk); #1;
    chk("sc_we", rf_we, rd != 5'd0);
  endtask

  task automatic lane(input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] d,
                      input logic rw, input logic rdy);
    set_res(sel, d);
    WB_rd = rd;
    WB_VRegWrite = 1'b1;
    WB_RegWrite = rw;
    vrf_ready = rdy;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    WB_VRegWrite = 1'b0;
    WB_RegWrite = 1'b0;
    vrf_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // scoreboard monitor: sampled mid-cycle, vrf_ready here is what the next edge will see
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rf_we === 1'b1) begin
        if (sq.size() == 0) chk("rf_spurious", 1, 0);
        else begin
          se = sq.pop_front();
          chk("rf_waddr", rf_waddr, se.a);
          chk("rf_wdata", rf_wdata, se.d);
        end
      end
      if (hold) begin
        chk("vrf_hold_we", vrf_we, 1);
        chk("vrf_hold_addr_mask", {vrf_waddr, vrf_wmask}, {pa, pm});
        chk("vrf_hold_data", vrf_wdata, pd);
      end
      if (vrf_we === 1'b1 && vrf_ready) begin
        if (vq.size() == 0) chk("vrf_spurious", 1, 0);
        else begin
          ve = vq.pop_front();
          chk("vrf_waddr", vrf_waddr, ve.a);
          chk("vrf_wmask", vrf_wmask, ve.m);
          chk("vrf_wdata", vrf_wdata, ve.d);
        end
      end
      hold <= vrf_we === 1'b1 && !vrf_ready;
      pa <= vrf_waddr;
      pd <= vrf_wdata;
      pm <= vrf_wmask;
    end else hold <= 1'b0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    repeat (2) begin
      set_res(2'($urandom), $urandom);
      WB_rd = 5'($urandom);
      WB_RegWrite = 1'($urandom);
      WB_VRegWrite = 1'($urandom);
      vrf_ready = 1'($urandom);
      @(posedge clk); #1;
      chk("rst_rf", {rf_we, rf_waddr, rf_wdata}, 0);
      chk("rst_vrf_ctl", {vrf_we, vrf_waddr, vrf_wmask}, 0);
      chk("rst_vrf_data", vrf_wdata, 0);
      chk("rst_stall", wb_stall, 0);
    end
    idle(0);
    rst_n = 1'b1;
    idle(1);

    sc(5'd7, 2'd3, 32'h01000000);
    chk("sc_addr", rf_waddr, 7);
    chk("sc_data", rf_wdata, 32'h01000000);
    sc(5'd0, 2'd3, 32'h01000000);
    sc(5'd12, 2'd1, 32'hDEADBEEF);
    sc(5'd13, 2'd2, 32'h00000063);
    sc(5'd14, 2'd0, 32'h12345678);
    idle(1);

    sq.push_back('{a: 5'd3, d: 32'h11111111});
    lane(5'd3, 2'd0, 32'h11111111, 1'b1, 1'b1);
    lane(5'd3, 2'd0, 32'h22222222, 1'b0, 1'b1);
    lane(5'd3, 2'd0, 32'h33333333, 1'b0, 1'b1);
    chk("fp_early", vrf_we, 0);
    vq.push_back('{a: 5'd3, d: 128'h44444444_33333333_22222222_11111111, m: 4'hF});
    lane(5'd3, 2'd0, 32'h44444444, 1'b0, 1'b1);
    chk("fp_latency", vrf_we, 1);
    idle(1);
    chk("fp_single", vrf_we, 0);

    lane(5'd3, 2'd1, 32'h0000000A, 1'b0, 1'b1);
    lane(5'd3, 2'd1, 32'h0000000B, 1'b0, 1'b1);
    vq.push_back('{a: 5'd3, d: 128'h0000000B_0000000A, m: 4'h3});
    lane(5'd5, 2'd1, 32'h00000051, 1'b0, 1'b1);
    chk("pf_we", vrf_we, 1);
    lane(5'd5, 2'd2, 32'h00000052, 1'b0, 1'b1);
    lane(5'd5, 2'd3, 32'h00000053, 1'b0, 1'b1);
    vq.push_back('{a: 5'd5, d: 128'h00000054_00000053_00000052_00000051, m: 4'hF});
    lane(5'd5, 2'd0, 32'h00000054, 1'b0, 1'b1);
    idle(1);

    vq.push_back('{a: 5'd4, d: 128'hA0000004_A0000003_A0000002_A0000001, m: 4'hF});
    for (int i = 1; i <= 4; i++) lane(5'd4, 2'd0, 32'hA0000000 + i, 1'b0, 1'b0);
    chk("bp_we", vrf_we, 1);
    for (int i = 1; i <= 3; i++) lane(5'd8, 2'd1, 32'hB0000000 + i, 1'b0, 1'b0);
    chk("bp_addr_held", vrf_waddr, 4);
    vq.push_back('{a: 5'd8, d: 128'hB0000004_B0000003_B0000002_B0000001, m: 4'hF});
    set_res(2'd1, 32'hB0000004);
    WB_rd = 5'd8;
    vrf_ready = 1'b0;
    #1;
    chk("bp_stall1", wb_stall, 1);
    @(posedge clk); #1;
    chk("bp_stall2", wb_stall, 1);
    vrf_ready = 1'b1;
    #1;
    chk("bp_stall_rel", wb_stall, 0);
    @(posedge clk); #1;
    chk("bp_reload", {vrf_we, vrf_waddr}, {1'b1, 5'd8});
    idle(2);

    lane(5'd6, 2'd0, 32'h00000061, 1'b0, 1'b1);
    lane(5'd6, 2'd0, 32'h00000062, 1'b0, 1'b1);
    WB_VRegWrite = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    vq.push_back('{a: 5'd9, d: 128'h90000004_90000003_90000002_90000001, m: 4'hF});
    for (int i = 1; i <= 4; i++) lane(5'd9, 2'd0, 32'h90000000 + i, 1'b0, 1'b1);
    idle(3);

    for (int i = 0; i < 20 && (sq.size() != 0 || vq.size() != 0); i++) idle(1);
    chk("sq_drained", sq.size(), 0);
    chk("vq_drained", vq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_writeback_unit.md
# wb_writeback_unit

Write-back stage of the SIMD AES pipeline. It consumes the MEM/WB register outputs and selects the result source: ALU, memory, S-box or Rcon. It drives the scalar register-file write port directly. Vector results arrive one 32-bit lane per cycle; the unit packs four lanes into a 128-bit vector register write and handles back-pressure from the vector register file.

## Interface
- DATA_W, 32, width of one lane / scalar word
- LANES, 4, lanes per vector register (vector width = DATA_W*LANES)
- REG_AW, 5, register address width
- clk  in  1  pipeline clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- WB_MemData, WB_ALUResult, WB_sbox, WB_rcon  in  DATA_W each  candidate results
- WB_rd  in  REG_AW  destination register
- WB_MemToReg  in  2  result select: 00 ALU, 01 Mem, 10 sbox, 11 rcon
- WB_RegWrite  in  1  scalar write request
- WB_VRegWrite  in  1  vector lane write request
- vrf_ready  in  1  vector register file accepts vrf_we this cycle
- rf_we  out  1  scalar write enable
- rf_waddr  out  REG_AW  scalar write address
- rf_wdata  out  DATA_W  scalar write data
- vrf_we  out  1  vector write valid (held until vrf_ready)
- vrf_waddr  out  REG_AW  vector write address
- vrf_wdata  out  DATA_W*LANES  packed vector, lane i at bits [DATA_W*i +: DATA_W]
- vrf_wmask  out  LANES  lane enables
- wb_stall  out  1  combinational; upstream must hold the current WB_* inputs

## Operation
- result = mux(WB_MemToReg). The same result feeds both the scalar and the vector paths. RegWrite and VRegWrite together are legal and each is honoured.
- Scalar path: when WB_RegWrite=1 and WB_rd≠0, register rf_we=1, rf_waddr=WB_rd, rf_wdata=result. If WB_rd=0, rf_we=0. The scalar path is never stalled.
- Vector packer states: IDLE (count=0), FILL (count 1..LANES-1), PEND (output buffer holds an unaccepted write).
- Lane accept in IDLE: store result in lane 0, latch tgt_rd=WB_rd, count=1.
- Lane accept in FILL with WB_rd=tgt_rd: store result in lane count, then count+1. When count reaches LANES, emit with mask all ones and set count=0.
- Lane accept in FILL with WB_rd≠tgt_rd: flush the partial vector with mask bits [count-1:0] set. The new lane starts a fresh accumulation at lane 0 with count=1.
- Emit: load the output buffer (vrf_we=1, addr, data, mask). Unused lanes in vrf_wdata are 0.
- Buffer handshake: the buffer clears on the cycle vrf_we&vrf_ready. vrf_we, addr, data and mask stay stable until then.
- wb_stall = vrf_we & ~vrf_ready & (the current input would emit). While wb_stall=1, no vector lane is consumed and the packer state is unchanged.
- An emit in the same cycle as an accept (vrf_ready=1) reloads the buffer with no bubble.

## Timing
- Reset (rst_n=0 at a clk edge) forces all registered outputs to 0, count=0 and tgt_rd=0. Partial and pending vectors are discarded.
- Scalar latency: 1 cycle from input sample to rf_we.
- Vector latency: vrf_we rises 1 cycle after the 4th lane is sampled.
- Throughput: 1 lane/cycle sustained while vrf_ready=1.
- A vector write is only ever emitted by a full pack or by an rd change. There is no timeout flush.

## Configuration
- WB_FWD_EN defined: adds the outputs fwd_valid (1), fwd_rd (REG_AW) and fwd_data (DATA_W).
  - These are combinational copies of the current scalar write (RegWrite & rd≠0, result) for the EX bypass.
- WB_FWD_EN not defined: these ports are absent and no bypass logic is generated.

## Structure
- Package wb_pkg holds:
  - enum memtoreg_e {MTR_ALU, MTR_MEM, MTR_SBOX, MTR_RCON}
  - packer state enum {IDLE, FILL, PEND}
  - the LANES and DATA_W defaults
- Sub-module vreg_packer contains the lane counter, the accumulation register, the output buffer and the stall logic. The top-level unit contains the mux and the scalar path.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with random inputs → all outputs 0 and wb_stall=0. Then release.
- Scalar write: RegWrite=1, rd=7, MemToReg=11, rcon=0x01000000 → next cycle rf_we=1, rf_waddr=7, rf_wdata=0x01000000. The same stimulus with rd=0 gives rf_we=0.
- Full pack: 4 consecutive VRegWrite lanes to rd=3 with ALUResult 0x11111111, 0x22222222, 0x33333333, 0x44444444 and vrf_ready=1 → one cycle with vrf_we=1, vrf_waddr=3, vrf_wdata=0x44444444_33333333_22222222_11111111, vrf_wmask=1111.
- Partial flush: 2 lanes to rd=3 (0xA, 0xB), then 1 lane to rd=5 → vrf_we with addr 3, mask 0011, data 0x..._0000000B_0000000A. After that, count=1 for rd=5.
- Back-pressure: the full pack completes with vrf_ready=0 for 3 cycles while a second group of 4 lanes streams in → vrf_we and its data stay stable. wb_stall=1 on the 4th lane of the 2nd group until vrf_ready=1. Both vectors are written in order with no lane lost.
- Reset mid-fill: reset after 2 lanes, then 4 lanes to rd=9 → only the rd=9 vector is written, with mask 1111.
